scan_judge: RTL and testbench

- Responder side of the bin-search loop: accepts the bin under test (`speed`) from the binary-search controller and runs one scan capture at that setting.
- Compacts the serial scan-out stream into a MISR signature and compares it against the golden signature.
- Returns a held `pass` verdict plus a one-cycle `scan_done` pulse; the controller consumes these to narrow hibin/lobin.
- Stops issuing scans once the controller raises `over`.

---
 rtl/scan_judge_if.sv | 28 ++
 rtl/scan_judge.sv | 123 ++++++++++++
 tb/tb_scan_judge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_judge_if.sv
// Bundle between the bin-search controller and the scan judge.
// The master drives the bin, enables and golden signature; the slave returns scan status and verdict.
interface scan_judge_if #(
  parameter int unsigned sigLength = 13
);
  logic                 en;
  logic [9:0]           speed;
  logic                 over;
  logic                 scan_out;
  logic [sigLength-1:0] golden;
  logic                 scan_en;
  logic [9:0]           bin_applied;
  logic [sigLength-1:0] sig;
  logic                 pass;
  logic                 scan_done;
  logic                 busy;
  logic [8:0]           scan_cnt;

  modport master (
    output en, speed, over, scan_out, golden,
    input  scan_en, bin_applied, sig, pass, scan_done, busy, scan_cnt
  );

  modport slave (
    input  en, speed, over, scan_out, golden,
    output scan_en, bin_applied, sig, pass, scan_done, busy, scan_cnt
  );
endinterface

// File: rtl/scan_judge.sv
// Runs one settle + scan-shift capture per bin, compacts scan_out into a MISR
// and reports a held pass verdict against the golden signature.
module scan_judge #(
  parameter int unsigned          sigLength  = 13,
  parameter logic [sigLength-1:0] POLY       = 13'h001B,
  parameter int unsigned          SCAN_LEN   = 64,
  parameter int unsigned          SETTLE_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_judge_if.slave     bus
);

  typedef enum logic [2:0] {StIdle, StSettle, StShift, StCompare, StDone} state_e;

  localparam logic [7:0]  SettleLast = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] ShiftLast  = 16'(SCAN_LEN - 1);

  state_e               state_q, state_d;
  logic [9:0]           bin_q, bin_d;
  logic [7:0]           settle_q, settle_d;
  logic [15:0]          shift_q, shift_d;
  logic [sigLength-1:0] sig_q, sig_d;
  logic                 pass_q, pass_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [sigLength-1:0] misr_next;

  assign misr_next = {sig_q[sigLength-2:0], 1'b0}
                   ^ (sig_q[sigLength-1] ? POLY : '0)
                   ^ {{(sigLength-1){1'b0}}, bus.scan_out};

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    settle_d = settle_q;
    shift_d  = shift_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.en && !bus.over) begin
          state_d  = StSettle;
          bin_d    = bus.speed;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (!bus.en) begin
          state_d = StIdle;
        end else if (bus.speed != bin_q) begin
          bin_d    = bus.speed;
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          state_d = StShift;
          sig_d   = '0;
          shift_d = '0;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StShift: begin
        // A bin change invalidates the capture; en=0 alone lets it finish.
        if (bus.speed != bin_q) begin
          state_d  = StSettle;
          bin_d    = bus.speed;
          settle_d = '0;
        end else begin
          sig_d = misr_next;
          if (shift_q == ShiftLast) begin
            state_d = StCompare;
          end else begin
            shift_d = shift_q + 16'd1;
          end
        end
      end
      StCompare: begin
        pass_d  = (sig_q == bus.golden);
        cnt_d   = cnt_q + 9'd1;
        state_d = StDone;
      end
      StDone: begin
        if (bus.en && !bus.over) begin
          state_d  = StSettle;
          bin_d    = bus.speed;
          settle_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      bin_q    <= '0;
      settle_q <= '0;
      shift_q  <= '0;
      sig_q    <= '0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      settle_q <= settle_d;
      shift_q  <= shift_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.scan_en     = (state_q == StShift);
  assign bus.scan_done   = (state_q == StDone);
  assign bus.busy        = (state_q != StIdle);
  assign bus.bin_applied = bin_q;
  assign bus.sig         = sig_q;
  assign bus.pass        = pass_q;
  assign bus.scan_cnt    = cnt_q;

endmodule

// File: tb/tb_scan_judge.sv
// Bench for scan_judge: vector table, randomized scans against a polynomial MISR model,
// and hand-written abort / over / reset sequences.
module tb_scan_judge;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_cnt;
  logic exp_pass;

  scan_judge_if #(.sigLength(13)) bus ();

  scan_judge dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] bits;
    logic [12:0] gold;
    logic [12:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signature = sum of bit_i * x^(63-i) mod (x^13+x^4+x^3+x+1); bit 0 is shifted in first.
  function automatic logic [12:0] model_sig(input logic [63:0] bits);
    logic [12:0] pw;
    logic [12:0] r;
    pw = 13'h0001;
    r  = '0;
    for (int i = 63; i >= 0; i--) begin
      if (bits[i]) r ^= pw;
      pw = pw[12] ? ({pw[11:0], 1'b0} ^ 13'h001B) : {pw[11:0], 1'b0};
    end
    return r;
  endfunction

  // Entered at #1 after an edge with the DUT idle; the next edge starts the scan.
  task automatic run_scan(input string name, input logic [63:0] bits, input logic [12:0] gold,
                          input logic [9:0] spd, input logic [12:0] esig, input logic epass);
    int bad_en, bad_done, bad_hold;
    bad_en = 0; bad_done = 0; bad_hold = 0;
    bus.golden = gold; bus.speed = spd; bus.over = 1'b0; bus.scan_out = 1'b0; bus.en = 1'b1;
    for (int c = 1; c <= 82; c++) begin
      tick();
      if (bus.scan_en !== ((c >= 17 && c <= 80) ? 1'b1 : 1'b0)) bad_en++;
      if (bus.scan_done !== ((c == 82) ? 1'b1 : 1'b0)) bad_done++;
      if (c <= 81 && bus.pass !== exp_pass) bad_hold++;
      bus.scan_out = (c >= 17 && c <= 80) ? bits[c-17] : 1'b0;
      if (c == 82) begin
        exp_cnt  = (exp_cnt + 1) % 512;
        exp_pass = epass;
        check({name, " sig"}, 32'(bus.sig), 32'(esig));
        check({name, " pass"}, 32'(bus.pass), 32'(epass));
        check({name, " scan_cnt"}, 32'(bus.scan_cnt), 32'(exp_cnt));
        check({name, " bin_applied"}, 32'(bus.bin_applied), 32'(spd));
        bus.en = 1'b0;
      end
    end
    check({name, " scan_en window errs"}, 32'(bad_en), 32'd0);
    check({name, " scan_done timing errs"}, 32'(bad_done), 32'd0);
    check({name, " pass hold errs"}, 32'(bad_hold), 32'd0);
    tick();
    check({name, " idle busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [63:0] ones;
    logic [63:0] last_only;
    int          done_c;
    int          n_done;
    int          d1, d2;
    int          late_en;

    checks = 0; errors = 0; exp_cnt = 0; exp_pass = 1'b0;
    ones = '1;
    last_only = 64'h8000_0000_0000_0000;
    vecs[0] = '{"zero",      64'h0,     13'h0000, 13'h0000, 1'b1};
    vecs[1] = '{"last_g1",   last_only, 13'h0001, 13'h0001, 1'b1};
    vecs[2] = '{"last_g0",   last_only, 13'h0000, 13'h0001, 1'b0};
    vecs[3] = '{"last_g1b",  last_only, 13'h0001, 13'h0001, 1'b1};
    vecs[4] = '{"ones_gm",   ones, model_sig(ones), model_sig(ones), 1'b1};
    vecs[5] = '{"ones_gbad", ones, model_sig(ones) ^ 13'h0100, model_sig(ones), 1'b0};

    rst_n = 1'b0; bus.en = 1'b0; bus.speed = '0; bus.over = 1'b0;
    bus.scan_out = 1'b0; bus.golden = '0;
    #12;
    check("reset outputs",
          32'({bus.scan_en, bus.bin_applied, bus.sig, bus.pass, bus.scan_done, bus.busy}), 32'd0);
    check("reset scan_cnt", 32'(bus.scan_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      run_scan(vecs[i].name, vecs[i].bits, vecs[i].gold, 10'(i + 3), vecs[i].exp_sig,
               vecs[i].exp_pass);

    for (int r = 0; r < 8; r++) begin
      logic [63:0] b;
      logic [12:0] m, g;
      b = {$urandom(), $urandom()};
      m = model_sig(b);
      g = ($urandom_range(0, 1) == 1) ? m : 13'($urandom());
      run_scan($sformatf("rand%0d", r), b, g, 10'($urandom_range(0, 1023)), m, (g == m));
    end

    // Bin change mid-shift aborts the scan and restarts settling.
    bus.golden = '0; bus.scan_out = 1'b0; bus.speed = 10'd40; bus.en = 1'b1;
    done_c = -1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c == 29) begin
        check("abort pre scan_en", 32'(bus.scan_en), 32'd1);
        check("abort pre bin", 32'(bus.bin_applied), 32'd40);
      end
      if (c == 30) bus.speed = 10'd20;
      if (c == 31) begin
        check("abort scan_en drop", 32'(bus.scan_en), 32'd0);
        check("abort bin relatch", 32'(bus.bin_applied), 32'd20);
      end
      if (bus.scan_done === 1'b1) begin
        done_c = c;
        break;
      end
    end
    check("abort done cycle", 32'(done_c), 32'd112);
    bus.en = 1'b0;
    exp_cnt = exp_cnt + 1; exp_pass = 1'b1;
    tick();
    check("abort scan_cnt", 32'(bus.scan_cnt), 32'(exp_cnt));
    check("abort pass", 32'(bus.pass), 32'd1);

    // over raised during the second scan's shift.
    bus.speed = 10'd5; bus.en = 1'b1;
    n_done = 0; d1 = -1; d2 = -1; late_en = 0;
    for (int c = 1; c <= 260; c++) begin
      tick();
      if (c == 120) bus.over = 1'b1;
      if (bus.scan_done === 1'b1) begin
        n_done++;
        if (n_done == 1) d1 = c;
        if (n_done == 2) d2 = c;
      end
      if (c == 165) check("over idle busy", 32'(bus.busy), 32'd0);
      if (c > 164 && bus.scan_en !== 1'b0) late_en++;
    end
    exp_cnt = exp_cnt + 2;
    check("over first done", 32'(d1), 32'd82);
    check("over second done", 32'(d2), 32'd164);
    check("over done count", 32'(n_done), 32'd2);
    check("over no new scan_en", 32'(late_en), 32'd0);
    check("over scan_cnt", 32'(bus.scan_cnt), 32'(exp_cnt));
    bus.over = 1'b0; bus.en = 1'b0;
    tick();

    // Asynchronous reset mid-shift, then a fresh scan after release.
    bus.speed = 10'd7; bus.en = 1'b1;
    for (int c = 1; c <= 50; c++) tick();
    check("pre-reset scan_en", 32'(bus.scan_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset outputs",
          32'({bus.scan_en, bus.bin_applied, bus.sig, bus.pass, bus.scan_done, bus.busy}), 32'd0);
    check("async reset scan_cnt", 32'(bus.scan_cnt), 32'd0);
    #2 rst_n = 1'b1;
    exp_cnt = 0;
    done_c = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (bus.scan_done === 1'b1) begin
        done_c = c;
        break;
      end
    end
    check("post-reset done cycle", 32'(done_c), 32'd82);
    check("post-reset scan_cnt", 32'(bus.scan_cnt), 32'd1);
    check("post-reset pass", 32'(bus.pass), 32'd1);
    bus.en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
